// File: rtl/led_chaser_gen.sv
// LED chaser: moves a contiguous lit group across the LED bank once per step period.
// Optional LED_CHASER_SPEED_EN adds a speed[1:0] input that divides the step period.
module led_chaser_gen #(
    parameter int unsigned LED_W  = 16,
    parameter int unsigned LEN_W  = 4,
    parameter int unsigned PERIOD = 100_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn,
    input  logic [LEN_W-1:0] len,
    input  logic [1:0]       mode,
`ifdef LED_CHASER_SPEED_EN
    input  logic [1:0]       speed,
`endif
    output logic [LED_W-1:0] led,
    output logic             step,
    output logic             running
);

    localparam int unsigned PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StPause} state_e;

    state_e           state;
    logic             btn_q;
    logic [LEN_W-1:0] len_q;
    logic [PW-1:0]    presc;
    logic             dir_right;
    logic [PW-1:0]    p_last;
    logic             btn_edge;
    logic             len_chg;
    logic             wrap;
    logic [LED_W-1:0] led_mv;
    logic             dir_mv;

`ifdef LED_CHASER_SPEED_EN
    function automatic logic [PW-1:0] last_for(input logic [1:0] s);
        int unsigned p;
        p = PERIOD >> s;
        if (p < 2) p = 2;
        return PW'(p - 1);
    endfunction
`else
    assign p_last = PW'(PERIOD - 1);
`endif

    // Bits 0..len lit; saturates to all ones once len+1 reaches LED_W.
    function automatic logic [LED_W-1:0] group_ones(input logic [LEN_W-1:0] l);
        logic [LED_W-1:0] g;
        for (int i = 0; i < LED_W; i++) g[i] = (i <= int'(l));
        return g;
    endfunction

    assign btn_edge = btn & ~btn_q;
    assign len_chg  = (len != len_q);
    assign wrap     = (presc == p_last);

    always_comb begin
        led_mv = led;
        dir_mv = dir_right;
        case (mode)
            2'b00: led_mv = {led[LED_W-2:0], led[LED_W-1]};
            2'b01: led_mv = {led[0], led[LED_W-1:1]};
            2'b10: begin
                if (!(&led)) begin
                    // Both edges lit without being full means the group wraps around:
                    // shift in the current direction so the wrapped bit falls off.
                    if (led[LED_W-1] && led[0]) begin
                        led_mv = dir_right ? (led >> 1) : (led << 1);
                    end else if (!dir_right && led[LED_W-1]) begin
                        dir_mv = 1'b1;
                        led_mv = led >> 1;
                    end else if (dir_right && led[0]) begin
                        dir_mv = 1'b0;
                        led_mv = led << 1;
                    end else begin
                        led_mv = dir_right ? (led >> 1) : (led << 1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            btn_q     <= 1'b0;
            len_q     <= '0;
            presc     <= '0;
            dir_right <= 1'b0;
            led       <= '0;
            step      <= 1'b0;
            running   <= 1'b0;
`ifdef LED_CHASER_SPEED_EN
            p_last    <= PW'(PERIOD - 1);
`endif
        end else begin
            btn_q <= btn;
            len_q <= len;
            step  <= 1'b0;
            case (state)
                StIdle: begin
                    led     <= '0;
                    running <= 1'b0;
                    if (btn_edge) state <= StLoad;
                end
                StLoad: begin
                    // len_q takes this same value now, so no spurious reload follows.
                    led       <= group_ones(len);
                    presc     <= '0;
                    dir_right <= 1'b0;
                    state     <= StRun;
                    running   <= 1'b1;
`ifdef LED_CHASER_SPEED_EN
                    p_last    <= last_for(speed);
`endif
                end
                StRun: begin
                    if (len_chg) begin
                        state   <= StLoad;
                        running <= 1'b0;
                    end else begin
                        if (wrap) begin
                            presc     <= '0;
                            step      <= 1'b1;
                            led       <= led_mv;
                            dir_right <= dir_mv;
`ifdef LED_CHASER_SPEED_EN
                            p_last    <= last_for(speed);
`endif
                        end else begin
                            presc <= presc + 1'b1;
                        end
                        if (btn_edge) begin
                            state   <= StPause;
                            running <= 1'b0;
                        end
                    end
                end
                StPause: begin
                    if (len_chg) begin
                        state <= StLoad;
                    end else if (btn_edge) begin
                        state   <= StRun;
                        running <= 1'b1;
                    end
                end
                default: begin
                    state   <= StIdle;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_chaser_gen.sv
// Scoreboard bench for led_chaser_gen (LED_W=8, LEN_W=3, PERIOD=4): expected steps are
// queued with their cycle number and a negedge monitor checks every step pulse.
module tb_led_chaser_gen;

    typedef struct {
        logic [7:0] led;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn;
    logic [2:0] len;
    logic [1:0] mode;
`ifdef LED_CHASER_SPEED_EN
    logic [1:0] speed = 2'b00;
`endif
    logic [7:0] led;
    logic       step;
    logic       running;

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t q[$];

    led_chaser_gen #(.LED_W(8), .LEN_W(3), .PERIOD(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn     (btn),
        .len     (len),
        .mode    (mode),
`ifdef LED_CHASER_SPEED_EN
        .speed   (speed),
`endif
        .led     (led),
        .step    (step),
        .running (running)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Returns 1 time unit after posedge n.
    task automatic at(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic to_neg(input int n);
        at(n);
        #4;
    endtask

    task automatic press();
        btn = 1'b1;
        at(cyc + 1);
        btn = 1'b0;
    endtask

    task automatic push(input logic [7:0] v, input int c);
        exp_t e;
        e.led = v;
        e.cyc = c;
        q.push_back(e);
    endtask

    initial begin
        logic [7:0] pp [13];
        rst_n = 1'b0;
        btn   = 1'b0;
        len   = 3'd0;
        mode  = 2'b00;
        #2;
        chk("reset_led", led, 8'h00);
        chk("reset_step", step, 1'b0);
        chk("reset_running", running, 1'b0);
        #20 rst_n = 1'b1;

        fork
            begin
                // Rotate-left, 3 lit: edge at 4, LOAD at 5, steps every 4 clks.
                at(3);
                len  = 3'd2;
                mode = 2'b00;
                press();
                to_neg(5);
                chk("load_led", led, 8'b0000_0111);
                chk("load_running", running, 1'b1);
                push(8'b0000_1110, 9);
                push(8'b0001_1100, 13);
                push(8'b0011_1000, 17);
                push(8'b0111_0000, 21);

                // Pause edge coinciding with the wrap at 21: step taken, then frozen.
                at(20);
                press();
                to_neg(21);
                chk("pause_running", running, 1'b0);
                to_neg(30);
                chk("pause_led_a", led, 8'b0111_0000);
                to_neg(39);
                chk("pause_led_b", led, 8'b0111_0000);
                chk("pause_running_b", running, 1'b0);
                at(40);
                press();
                push(8'b1110_0000, 45);
                push(8'b1100_0001, 49);
                to_neg(42);
                chk("resume_running", running, 1'b1);

                // Ping-pong, 2 lit: reload at 50, LOAD at 51.
                at(49);
                len  = 3'd1;
                mode = 2'b10;
                pp = '{8'b0000_0110, 8'b0000_1100, 8'b0001_1000, 8'b0011_0000, 8'b0110_0000,
                       8'b1100_0000, 8'b0110_0000, 8'b0011_0000, 8'b0001_1000, 8'b0000_1100,
                       8'b0000_0110, 8'b0000_0011, 8'b0000_0110};
                for (int i = 0; i < 13; i++) push(pp[i], 55 + 4 * i);
                to_neg(51);
                chk("pp_load_led", led, 8'b0000_0011);

                // len 1->4 mid-run: LOAD state one clk later, new group the clk after.
                at(103);
                len  = 3'd4;
                mode = 2'b01;
                push(8'b1000_1111, 109);
                push(8'b0001_1110, 113);
                push(8'b0011_1100, 117);
                push(8'b0111_1000, 121);
                push(8'b1111_0000, 125);
                push(8'b0111_1000, 129);
                to_neg(104);
                chk("reload_led_held", led, 8'b0000_0110);
                chk("reload_running", running, 1'b0);
                to_neg(105);
                chk("reload_led", led, 8'b0001_1111);
                chk("reload_run_again", running, 1'b1);
                // Switch to ping-pong while the group wraps around the edge.
                at(109);
                mode = 2'b10;

                // Full bank in ping-pong: static, still stepping.
                at(129);
                len = 3'd7;
                push(8'hFF, 135);
                push(8'hFF, 139);
                push(8'hFF, 143);
                to_neg(131);
                chk("full_led", led, 8'hFF);

                // Async reset between clock edges.
                at(145);
                #2 rst_n = 1'b0;
                #1;
                chk("async_led", led, 8'h00);
                chk("async_running", running, 1'b0);
                chk("async_step", step, 1'b0);
                #5 rst_n = 1'b1;
                to_neg(157);
                chk("idle_led", led, 8'h00);
                chk("idle_running", running, 1'b0);
                at(158);
                press();
                push(8'hFF, 164);
                to_neg(160);
                chk("restart_led", led, 8'hFF);
                chk("restart_running", running, 1'b1);
                to_neg(166);
                chk("queue_drained", q.size(), 0);
            end
            begin
                forever begin
                    @(negedge clk);
                    if (step) begin
                        if (q.size() == 0 || q[0].cyc != cyc) begin
                            tests++;
                            fails++;
                            $display("FAIL unexpected_step at cycle %0d: led=%b, expected no step",
                                     cyc, led);
                        end else begin
                            chk("step_led", led, q[0].led);
                            void'(q.pop_front());
                        end
                    end else if (q.size() != 0 && q[0].cyc <= cyc) begin
                        tests++;
                        fails++;
                        $display("FAIL missing_step at cycle %0d: step=0, expected step with led=%b",
                                 cyc, q[0].led);
                        void'(q.pop_front());
                    end
                end
            end
            begin
                #20000;
                tests++;
                fails++;
                $display("FAIL timeout: run still active at cycle %0d, expected done by 166", cyc);
            end
        join_any
        disable fork;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
